blink_monitor: RTL and testbench

Receive-side checker for the blink generator's `led`/`flg` output pair. It watches `led` transitions, measures the half-period between them, and checks that each transition is preceded by exactly one `flg` pulse. It declares lock after a run of good half-periods and latches a sticky fault on any deviation once locked. It sits beside the blinker in the Safety+Liveness examples as the consumer of that interface.

---
 rtl/blink_monitor.sv | 109 ++++++++++
 tb/tb_blink_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/blink_monitor.sv
// Receive-side checker for a blinker's led/flg pair: measures led half-periods,
// requires one flg pulse ahead of each led edge, locks after a run of good edges.
module blink_monitor #(
   parameter int CBITS    = 10,
   parameter int LOCK_CNT = 2,
   parameter int TOL      = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             led,
   input  logic             flg,
   output logic             locked,
   output logic             err,
   output logic [CBITS:0]   period,
   output logic [15:0]      toggles
);

   localparam int CW   = CBITS + 1;
   localparam int HALF = 1 << CBITS;
   localparam int GW   = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
   localparam logic [CW-1:0] LO     = CW'(HALF - TOL);
   localparam logic [CW-1:0] HI     = CW'(HALF + TOL);
   localparam logic [GW-1:0] LOCK_N = GW'(LOCK_CNT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEASURE,
      S_LOCKED,
      S_FAULT
   } state_t;

   state_t        state, state_nx;
   logic          seen, led_q, flg_q;
   logic [CW-1:0] hcnt, meas;
   logic [GW-1:0] good, good_nx, good_inc;
   logic          edge_det, hcnt_max, in_band, good_edge, spurious, timeout;

   assign edge_det  = seen & (led ^ led_q);
   assign hcnt_max  = &hcnt;
   // meas counts the edge cycle itself, so it is one more than hcnt
   assign meas      = hcnt_max ? hcnt : hcnt + CW'(1);
   assign in_band   = (meas >= LO) && (meas <= HI);
   assign good_edge = edge_det & in_band & flg_q;
   assign spurious  = flg_q & ~edge_det;
   assign timeout   = ~edge_det & (hcnt >= HI);
   assign good_inc  = good + GW'(1);

   always_comb begin
      state_nx = state;
      good_nx  = good;
      case (state)
         S_IDLE: begin
            if (edge_det) begin
               state_nx = S_MEASURE;
               good_nx  = '0;
            end
         end
         S_MEASURE: begin
            if (good_edge) begin
               if (good_inc == LOCK_N) begin
                  state_nx = S_LOCKED;
                  good_nx  = '0;
               end else begin
                  good_nx = good_inc;
               end
            end else if (edge_det || spurious) begin
               good_nx = '0;
            end
         end
         S_LOCKED: begin
            if ((edge_det && !good_edge) || spurious || timeout)
               state_nx = S_FAULT;
         end
         S_FAULT: state_nx = S_FAULT;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         seen    <= 1'b0;
         led_q   <= 1'b0;
         flg_q   <= 1'b0;
         hcnt    <= '0;
         good    <= '0;
         period  <= '0;
         toggles <= '0;
      end else begin
         state <= state_nx;
         good  <= good_nx;
         seen  <= 1'b1;
         led_q <= led;
         flg_q <= flg;
         if (edge_det) begin
            hcnt   <= '0;
            period <= meas;
            if (toggles != 16'hFFFF)
               toggles <= toggles + 16'd1;
         end else if (!hcnt_max) begin
            hcnt <= hcnt + CW'(1);
         end
      end
   end

   assign locked = (state == S_LOCKED);
   assign err    = (state == S_FAULT);

endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor with CBITS=3 (HALF=8), LOCK_CNT=2, TOL=0; a
// timestamp-based model predicts the outputs every cycle, literal checks pin it.
module tb_blink_monitor;

   localparam int CBITS    = 3;
   localparam int LOCK_CNT = 2;
   localparam int TOL      = 0;
   localparam int HALF     = 1 << CBITS;
   localparam int SAT      = (1 << (CBITS + 1)) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             led = 1'b0;
   logic             flg = 1'b0;
   logic             locked, err;
   logic [CBITS:0]   period;
   logic [15:0]      toggles;

   int n_checks = 0;
   int n_errs   = 0;
   bit chk_en   = 1'b0;
   logic cur_led = 1'b0;

   blink_monitor #(.CBITS(CBITS), .LOCK_CNT(LOCK_CNT), .TOL(TOL)) dut (
      .clk     (clk),
      .rst     (rst),
      .led     (led),
      .flg     (flg),
      .locked  (locked),
      .err     (err),
      .period  (period),
      .toggles (toggles)
   );

   always #5 clk = ~clk;

   // model: lock/fault decided from cycle stamps of edges and the previous flg
   int cyc = 0, last_edge = 0, run = 0, m_period = 0, m_tog = 0;
   bit m_seen = 0, prev_led = 0, prev_flg = 0;
   bit m_armed = 0, m_locked = 0, m_fault = 0;

   always @(posedge clk) begin
      int  elapsed, meas;
      bit  is_edge, good_e, spur, tmo;
      cyc++;
      if (rst) begin
         m_seen = 0; prev_led = 0; prev_flg = 0; last_edge = cyc;
         run = 0; m_period = 0; m_tog = 0;
         m_armed = 0; m_locked = 0; m_fault = 0;
      end else begin
         is_edge = m_seen && (led != prev_led);
         elapsed = cyc - last_edge;
         meas    = (elapsed > SAT) ? SAT : elapsed;
         good_e  = is_edge && prev_flg && meas >= HALF - TOL && meas <= HALF + TOL;
         spur    = prev_flg && !is_edge;
         tmo     = !is_edge && (elapsed - 1 >= HALF + TOL);
         if (is_edge) begin
            m_period  = meas;
            m_tog     = (m_tog == 65535) ? 65535 : m_tog + 1;
            last_edge = cyc;
         end
         if (m_fault) begin
         end else if (m_locked) begin
            if ((is_edge && !good_e) || spur || tmo) begin
               m_locked = 0;
               m_fault  = 1;
            end
         end else if (m_armed) begin
            if (good_e) begin
               run++;
               if (run == LOCK_CNT) begin
                  m_locked = 1;
                  run      = 0;
               end
            end else if (is_edge || spur) begin
               run = 0;
            end
         end else if (is_edge) begin
            m_armed = 1;
            run     = 0;
         end
         m_seen = 1; prev_led = led; prev_flg = flg;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_locked",  int'(locked),  int'(m_locked));
         check("cyc_err",     int'(err),     int'(m_fault));
         check("cyc_period",  int'(period),  m_period);
         check("cyc_toggles", int'(toggles), m_tog);
      end
   end

   task automatic step(input logic l, input logic f);
      led = l;
      flg = f;
      @(negedge clk);
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) step(cur_led, 1'b0);
   endtask

   // led toggles n cycles after the previous edge; flg optionally in the cycle before
   task automatic hp(input int n, input bit with_flg);
      for (int i = 1; i < n; i++) step(cur_led, with_flg && (i == n - 1));
      cur_led = ~cur_led;
      step(cur_led, 1'b0);
   endtask

   task automatic reset_step(input bit toggle);
      if (toggle) cur_led = ~cur_led;
      rst = 1'b1;
      led = cur_led;
      flg = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic expect_outs(input string tag, input int l, input int e, input int p, input int t);
      check({tag, "_locked"},  int'(locked),  l);
      check({tag, "_err"},     int'(err),     e);
      if (p >= 0) check({tag, "_period"},  int'(period),  p);
      if (t >= 0) check({tag, "_toggles"}, int'(toggles), t);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      reset_step(1'b0);
      chk_en = 1'b1;
      expect_outs("reset", 0, 0, 0, 0);

      // ideal lock
      hp(8, 1'b1);
      expect_outs("s1_edge1", 0, 0, -1, 1);
      hp(8, 1'b1);
      hp(8, 1'b1);
      expect_outs("s1_lock", 1, 0, 8, 3);

      // stall timeout, fault is sticky
      hold(8);
      expect_outs("s2_pre", 1, 0, 8, 3);
      hold(1);
      expect_outs("s2_tmo", 0, 1, 8, 3);
      for (int i = 0; i < 3; i++) hp(8, 1'b1);
      expect_outs("s2_sticky", 0, 1, 8, 6);

      // reset coincident with an edge, from FAULT then from LOCKED
      reset_step(1'b1);
      expect_outs("s6_rst_f", 0, 0, 0, 0);
      hp(8, 1'b1);
      expect_outs("s6_meas", 0, 0, 8, 1);
      hp(8, 1'b1);
      hp(8, 1'b1);
      expect_outs("s6_relock", 1, 0, 8, 3);
      hold(3);
      reset_step(1'b1);
      expect_outs("s6_rst_l", 0, 0, 0, 0);

      // short period
      reset_step(1'b0);
      for (int i = 0; i < 3; i++) hp(8, 1'b1);
      hp(7, 1'b1);
      expect_outs("s3_short", 0, 1, 7, 4);

      // long period
      reset_step(1'b0);
      for (int i = 0; i < 3; i++) hp(8, 1'b1);
      hp(9, 1'b1);
      expect_outs("s3_long", 0, 1, 9, 4);

      // missing flg before lock
      reset_step(1'b0);
      hp(8, 1'b1);
      hp(8, 1'b1);
      hp(8, 1'b0);
      expect_outs("s4_noflg", 0, 0, 8, 3);
      hp(8, 1'b1);
      expect_outs("s4_edge4", 0, 0, 8, 4);
      hp(8, 1'b1);
      expect_outs("s4_lock", 1, 0, 8, 5);

      // spurious flg while locked
      hold(3);
      step(cur_led, 1'b1);
      expect_outs("s5_pulse", 1, 0, 8, 5);
      step(cur_led, 1'b0);
      expect_outs("s5_fault", 0, 1, 8, 5);

      // spurious flg while measuring only clears the good run
      reset_step(1'b0);
      hp(8, 1'b1);
      hp(8, 1'b1);
      for (int i = 1; i < 8; i++) step(cur_led, (i == 3) || (i == 7));
      cur_led = ~cur_led;
      step(cur_led, 1'b0);
      expect_outs("s5_meas", 0, 0, 8, 3);
      hp(8, 1'b1);
      expect_outs("s5_relock", 1, 0, 8, 4);

      // long stall in MEASURE saturates the measured period
      reset_step(1'b0);
      hp(8, 1'b1);
      hold(20);
      cur_led = ~cur_led;
      step(cur_led, 1'b0);
      expect_outs("sat", 0, 0, SAT, 2);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
